// File: rtl/idm_access_ctrl.sv
// rtl/idm_access_ctrl.sv - requester-side arbiter/sequencer for the unified instruction/data memory
// Two-port (fetch/data) round-robin access controller: IDLE -> ACCESS -> RESP, 2 cycles per access.
module idm_access_ctrl #(
    parameter int AW    = 8,
    parameter int DEPTH = 64,
    parameter int RW    = 16,
    parameter int WW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [RW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [WW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [RW-1:0] d_rdata,
    output logic          err,
    output logic          busy,
    output logic [AW-1:0] mem_a,
    output logic [WW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [RW-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    state_t        state;
    state_t        state_next;
    logic          last_data;
    logic          we_r;
    logic          src_data;
    logic          oor;
    logic          any_gnt;
    logic [AW-1:0] sel_addr;
    logic [RW-1:0] rd_val;

    // last_data=0 means fetch was granted last, so data wins the first tie
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state != ACCESS && !rst) begin
            if (if_req && d_req) begin
                if (last_data) if_gnt = 1'b1;
                else           d_gnt  = 1'b1;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    assign any_gnt  = if_gnt | d_gnt;
    assign sel_addr = d_gnt ? d_addr : if_addr;
    assign rd_val   = (we_r || oor) ? '0 : mem_rd;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = any_gnt ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = any_gnt ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_we    = (state == ACCESS) && we_r && !oor && !rst;
        if_rvalid = (state == RESP) && !src_data;
        d_rvalid  = (state == RESP) && src_data;
        err       = (state == RESP) && oor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_a     <= '0;
            mem_wd    <= '0;
            we_r      <= 1'b0;
            src_data  <= 1'b0;
            oor       <= 1'b0;
            last_data <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (any_gnt) begin
                mem_a     <= sel_addr;
                we_r      <= d_gnt & d_we;
                src_data  <= d_gnt;
                oor       <= ({1'b0, sel_addr} >= DEPTH_W);
                last_data <= d_gnt;
                if (d_gnt) mem_wd <= d_wdata;
            end
            // The store commits at this same edge, so a later read sees it
            if (state == ACCESS) begin
                if (src_data) d_rdata  <= rd_val;
                else          if_rdata <= rd_val;
            end
        end
    end

endmodule

// File: doc/idm_access_ctrl.md
Name: idm_access_ctrl

Overview:
Requester-side controller for the unified instruction/data memory of the multicycle processor. It accepts instruction-fetch and data load/store requests from the core and arbitrates between them. It drives the memory's address, write-data and write-enable pins, samples the 16-bit read word and returns it to the requester with a valid pulse. Out-of-range addresses are blocked and flagged.

Parameters:
AW, 8, address width of mem_a, if_addr and d_addr
DEPTH, 64, number of implemented memory words; addresses >= DEPTH are out of range
RW, 16, read word width
WW, 8, write data width (memory zero-extends on write)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with stable if_addr until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  RW  fetched word
d_req  in  1  data request; held with stable d_we, d_addr, d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  WW  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  load data valid or store complete (1-cycle pulse)
d_rdata  out  RW  loaded word; 0 for stores
err  out  1  out-of-range access (pulses with the rvalid)
busy  out  1  state != IDLE
mem_a  out  AW  memory address
mem_wd  out  WW  memory write data
mem_we  out  1  memory write enable
mem_rd  in  RW  memory read data (combinational from mem_a)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. While rst=1 at a rising edge: state=IDLE, all outputs=0 (mem_a, mem_wd, rdata registers included), last_grant=FETCH so that data wins the first tie. Reset mid-operation aborts the access. mem_we is forced to 0 during any cycle with rst=1, so no partial write occurs.
- States: IDLE, ACCESS, RESP.
- Grant (combinational): allowed when state is IDLE or RESP and rst=0.
  - Only one req high: grant it.
  - Both high: grant the requester not granted last; update last_grant.
  - At most one gnt per cycle; gnt is never asserted in ACCESS.
- On grant, at the clock edge:
  - Register the address into mem_a.
  - Register wdata into mem_wd, and we (data port only; the fetch port is read-only).
  - Register the source ID and the range check (addr >= DEPTH).
  - Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_we = registered we AND in-range.
  - Reads: mem_rd is sampled at the end of the cycle into the source's rdata register. Out-of-range reads latch 0.
  - Stores: the source's rdata latches 0.
  - Next state: RESP.
- RESP (1 cycle):
  - Source's rvalid=1; err=1 if the access was out of range.
  - rdata holds its value until the next response to the same port.
  - Next state: ACCESS if a new grant occurs this cycle, else IDLE.
- Latency: req in IDLE at cycle T -> gnt at T, mem_we/mem_a at T+1, rvalid at T+2. Sustained throughput is one access per 2 cycles.
- A read issued after a store to the same address returns the new value, since the store commits at the end of its ACCESS cycle.
- mem_a and mem_wd hold their last value in IDLE. mem_we=0 outside ACCESS.
- A request dropped before gnt is a protocol violation; no access occurs.
- Address wrap: none. Addresses >= DEPTH are out of range, never aliased.

Test Plan:
- Fetch read: memory model preloaded mem[56]=16'd20; if_req=1, if_addr=56 in IDLE -> if_gnt at T, mem_a=56 at T+1, if_rvalid=1 with if_rdata=20 at T+2, err=0, mem_we never 1.
- Store then load: d_we=1, d_addr=10, d_wdata=8'hA6 -> mem_we=1 only at T+1 with mem_a=10, mem_wd=8'hA6; d_rvalid at T+2, d_rdata=0. Next load from 10 -> d_rdata=16'h00A6.
- Simultaneous requests right after reset: if_req=d_req=1 -> d_gnt first, if_gnt in the following RESP cycle. A second tie afterward -> order alternates. No cycle has both gnts high.
- Out of range: d_we=1, d_addr=8'd200 -> mem_we stays 0, d_rvalid=1 with err=1 and d_rdata=0 at T+2. An out-of-range fetch returns if_rdata=0 with err=1.
- Back-to-back: d_req held high for 3 loads -> d_gnt at T, T+2, T+4 and d_rvalid at T+2, T+4, T+6; busy stays 1.
- Reset mid-store: assert rst in the ACCESS cycle of a store to addr 5 -> mem_we=0 that cycle, memory unchanged, all outputs 0 next cycle, state IDLE.
